// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divide/remainder unit.
package div_pkg;

   localparam int DIV_XLEN = 32;

   // Operation encodings as presented on i_op.
   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   // Control states of the divider.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10,
      ST_DONE = 2'b11
   } div_state_e;

   localparam logic [DIV_XLEN-1:0] DIV_ALL_ONES = {DIV_XLEN{1'b1}};
   localparam logic [DIV_XLEN-1:0] INT_MIN      = {1'b1, {(DIV_XLEN-1){1'b0}}};

   // Two's-complement negation of a full-width value.
   function automatic logic [DIV_XLEN-1:0] twos_neg(input logic [DIV_XLEN-1:0] v);
      return (~v) + {{(DIV_XLEN-1){1'b0}}, 1'b1};
   endfunction

   // Magnitude of an operand; signed operands with the MSB set are negated.
   // INT_MIN maps onto itself, which is its correct unsigned magnitude.
   function automatic logic [DIV_XLEN-1:0] magnitude(input logic [DIV_XLEN-1:0] v,
                                                     input logic            is_signed);
      return (is_signed && v[DIV_XLEN-1]) ? twos_neg(v) : v;
   endfunction

endpackage

// File: rtl/iterative_divider_fast_adder.sv
// FastAdder: block-structured adder, BLOCKCOUNT blocks of BITPERBLOCK bits,
// carry passed block to block. Used by the divider as its trial subtractor.
module FastAdder #(
   parameter int BLOCKCOUNT  = 8,
   parameter int BITPERBLOCK = 4
) (
   input  logic [BLOCKCOUNT*BITPERBLOCK-1:0] i_a,
   input  logic [BLOCKCOUNT*BITPERBLOCK-1:0] i_b,
   input  logic                              i_c,
   output logic [BLOCKCOUNT*BITPERBLOCK-1:0] o_s,
   output logic                              o_c
);

   logic [BLOCKCOUNT:0] carry_s;

   assign carry_s[0] = i_c;

   for (genvar k = 0; k < BLOCKCOUNT; k++) begin : g_block
      logic [BITPERBLOCK:0] blk_sum_s;
      assign blk_sum_s = {1'b0, i_a[k*BITPERBLOCK +: BITPERBLOCK]}
                       + {1'b0, i_b[k*BITPERBLOCK +: BITPERBLOCK]}
                       + {{BITPERBLOCK{1'b0}}, carry_s[k]};
      assign o_s[k*BITPERBLOCK +: BITPERBLOCK] = blk_sum_s[BITPERBLOCK-1:0];
      assign carry_s[k+1] = blk_sum_s[BITPERBLOCK];
   end

   assign o_c = carry_s[BLOCKCOUNT];

endmodule

// File: rtl/iterative_divider.sv
// iterative_divider: radix-2 restoring RV32M DIV/DIVU/REM/REMU unit.
// One quotient bit per cycle through a FastAdder trial subtractor, then a
// one-cycle sign fix. Divide-by-zero and signed overflow finish immediately.
// Optional build macro DIVIDER_EARLY_TERM_EN: when |a| < |b| the request
// also finishes immediately (quotient 0, remainder = dividend).
module iterative_divider
   import div_pkg::*;
#(
   parameter int XLEN        = DIV_XLEN,
   parameter int BLOCKCOUNT  = 8,
   parameter int BITPERBLOCK = 4
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [1:0]      i_op,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_result,
   output logic            o_busy
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   div_state_e      state_r, state_next_s;
   logic            is_rem_r, neg_q_r, neg_r_r;
   logic [XLEN-1:0] dividend_r, divisor_r, rem_r, quo_r, result_r;
   logic [CNT_W-1:0] cnt_r;
   logic            valid_r, ready_r, busy_r;

   // Request decode at the accept edge
   logic            accept_s, in_signed_s, in_is_rem_s, early_s;
   logic [XLEN-1:0] a_mag_s, b_mag_s;
   logic            special_s;
   logic [XLEN-1:0] special_result_s;

   assign accept_s    = i_valid && (state_r == ST_IDLE);
   assign in_signed_s = ~i_op[0];
   assign in_is_rem_s = i_op[1];
   assign a_mag_s     = magnitude(i_a, in_signed_s);
   assign b_mag_s     = magnitude(i_b, in_signed_s);

`ifdef DIVIDER_EARLY_TERM_EN
   assign early_s = (a_mag_s < b_mag_s);
`else
   assign early_s = 1'b0;
`endif

   // Trial subtraction: remainder shifted in the next dividend bit, minus divisor
   logic [XLEN-1:0] rem_shift_s, diff_s;
   logic            carry_s, take_s;

   assign rem_shift_s = {rem_r[XLEN-2:0], dividend_r[XLEN-1]};

   FastAdder #(
      .BLOCKCOUNT (BLOCKCOUNT),
      .BITPERBLOCK(BITPERBLOCK)
   ) u_trial_sub (
      .i_a(rem_shift_s),
      .i_b(~divisor_r),
      .i_c(1'b1),
      .o_s(diff_s),
      .o_c(carry_s)
   );

   // A remainder MSB shifted out makes the shifted value exceed any divisor,
   // so the subtraction must succeed even though the 32-bit adder shows a borrow.
   assign take_s = carry_s | rem_r[XLEN-1];

   // Sign-corrected final result
   logic [XLEN-1:0] fix_result_s;
   assign fix_result_s = is_rem_r ? (neg_r_r ? twos_neg(rem_r) : rem_r)
                                  : (neg_q_r ? twos_neg(quo_r) : quo_r);

   // Classify requests that finish without iterating and choose their result
   always_comb begin
      special_s        = 1'b0;
      special_result_s = {XLEN{1'b0}};
      if (i_b == {XLEN{1'b0}}) begin
         special_s        = 1'b1;
         special_result_s = in_is_rem_s ? i_a : DIV_ALL_ONES;
      end else if (in_signed_s && (i_a == INT_MIN) && (i_b == DIV_ALL_ONES)) begin
         special_s        = 1'b1;
         special_result_s = in_is_rem_s ? {XLEN{1'b0}} : INT_MIN;
      end else if (early_s) begin
         special_s        = 1'b1;
         special_result_s = in_is_rem_s ? i_a : {XLEN{1'b0}};
      end else begin
         special_s        = 1'b0;
         special_result_s = {XLEN{1'b0}};
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_next_s = special_s ? ST_DONE : ST_CALC;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (cnt_r == CNT_LAST) begin
               state_next_s = ST_FIX;
            end else begin
               state_next_s = ST_CALC;
            end
         end
         ST_FIX:  state_next_s = ST_DONE;
         ST_DONE: begin
            if (i_ready) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_DONE;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // State register and registered handshake/status outputs
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
         valid_r <= 1'b0;
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         valid_r <= (state_next_s == ST_DONE);
         ready_r <= (state_next_s == ST_IDLE);
         busy_r  <= (state_next_s != ST_IDLE);
      end
   end

   // Operand capture, restoring iterations and sign fix
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         is_rem_r   <= 1'b0;
         neg_q_r    <= 1'b0;
         neg_r_r    <= 1'b0;
         dividend_r <= {XLEN{1'b0}};
         divisor_r  <= {XLEN{1'b0}};
         rem_r      <= {XLEN{1'b0}};
         quo_r      <= {XLEN{1'b0}};
         cnt_r      <= {CNT_W{1'b0}};
         result_r   <= {XLEN{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  is_rem_r   <= in_is_rem_s;
                  neg_q_r    <= in_signed_s & (i_a[XLEN-1] ^ i_b[XLEN-1]);
                  neg_r_r    <= in_signed_s & i_a[XLEN-1];
                  dividend_r <= a_mag_s;
                  divisor_r  <= b_mag_s;
                  rem_r      <= {XLEN{1'b0}};
                  quo_r      <= {XLEN{1'b0}};
                  cnt_r      <= {CNT_W{1'b0}};
                  if (special_s) begin
                     result_r <= special_result_s;
                  end
               end
            end
            ST_CALC: begin
               rem_r      <= take_s ? diff_s : rem_shift_s;
               quo_r      <= {quo_r[XLEN-2:0], take_s};
               dividend_r <= {dividend_r[XLEN-2:0], 1'b0};
               cnt_r      <= cnt_r + CNT_ONE;
            end
            ST_FIX: begin
               result_r <= fix_result_s;
            end
            ST_DONE: begin
               result_r <= result_r;
            end
            default: begin
               result_r <= result_r;
            end
         endcase
      end
   end

   assign o_valid  = valid_r;
   assign o_ready  = ready_r;
   assign o_busy   = busy_r;
   assign o_result = result_r;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed cases, backpressure,
// mid-operation reset and randomized requests against an arithmetic model.
module tb_iterative_divider;
   import div_pkg::*;

`ifdef DIVIDER_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   localparam int FULL_LAT = 34;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [1:0]  i_op = 2'b00;
   logic [31:0] i_a = 32'd0;
   logic [31:0] i_b = 32'd0;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic [31:0] o_result;
   logic        o_busy;

   int tests_run = 0;
   int tests_failed = 0;

   iterative_divider dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_op(i_op), .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready),
      .o_result(o_result), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference result from RV32M rules using plain arithmetic.
   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      bit is_signed = (op == OP_DIV) || (op == OP_REM);
      bit is_rem = (op == OP_REM) || (op == OP_REMU);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
      if (is_signed) return is_rem ? 32'(sa % sb) : 32'(sa / sb);
      return is_rem ? (a % b) : (a / b);
   endfunction

   // Reference latency in edges, counting the accepting edge as the first.
   function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
      bit is_signed = (op == OP_DIV) || (op == OP_REM);
      longint ma = (is_signed && a[31]) ? -longint'($signed(a)) : longint'(a);
      longint mb = (is_signed && b[31]) ? -longint'($signed(b)) : longint'(b);
      if (b == 32'd0) return 1;
      if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      if (EARLY && ma < mb) return 1;
      return FULL_LAT;
   endfunction

   // Wait (bounded) for o_ready, then present one request through its accept edge.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      while (!o_ready && n < 100) begin
         @(posedge i_clk); #1; n++;
      end
      check("ready_before_issue", {31'd0, o_ready}, 32'd1);
      i_valid = 1'b1; i_op = op; i_a = a; i_b = b;
      @(posedge i_clk); #1;
      i_valid = 1'b0; i_op = 2'($urandom); i_a = $urandom; i_b = $urandom;
   endtask

   // Full request: issue, measure latency, check result, hold, release.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
      int lat;
      logic [31:0] exp = ref_result(op, a, b);
      int exp_lat = ref_latency(op, a, b);
      issue(op, a, b);
      lat = 1;
      if (exp_lat > 1) check({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
      while (!o_valid && lat < 60) begin
         @(posedge i_clk); #1; lat++;
      end
      check({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_result"}, o_result, exp);
      repeat (hold) begin @(posedge i_clk); #1; end
      if (hold > 0) check({tag, "_held"}, o_result, exp);
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
      check({tag, "_released"}, {30'd0, o_ready, o_valid}, 32'd2);
   endtask

   initial begin
      logic [31:0] held;
      // Reset state
      i_rst_n = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      check("reset_valid", {31'd0, o_valid}, 32'd0);
      check("reset_ready", {31'd0, o_ready}, 32'd1);
      check("reset_busy", {31'd0, o_busy}, 32'd0);
      check("reset_result", o_result, 32'd0);
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;

      // Directed arithmetic cases
      run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 0);
      run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 0);
      run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
      run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 0);
      run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 0);
      run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 0);
      run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 0);
      run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 0);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("divu_3_9", OP_DIVU, 32'd3, 32'd9, 0);
      run_op("rem_m3_9", OP_REM, 32'hFFFF_FFFD, 32'd9, 0);
      run_op("div_big", OP_DIV, 32'h8000_0000, 32'd3, 2);

      // Backpressure: hold i_ready low in DONE with a competing request
      issue(OP_DIVU, 32'd1000, 32'd9);
      for (int n = 0; n < 60 && !o_valid; n++) begin @(posedge i_clk); #1; end
      check("bp_valid", {31'd0, o_valid}, 32'd1);
      held = o_result;
      check("bp_result", held, 32'd111);
      i_valid = 1'b1; i_op = OP_DIVU; i_a = 32'd50; i_b = 32'd0;
      for (int k = 0; k < 5; k++) begin
         @(posedge i_clk); #1;
         check("bp_hold_result", o_result, 32'd111);
         check("bp_hold_flags", {29'd0, o_valid, o_ready, o_busy}, 32'd5);
      end
      i_valid = 1'b0; i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
      check("bp_release", {29'd0, o_valid, o_ready, o_busy}, 32'd2);
      repeat (2) begin @(posedge i_clk); #1; end
      check("bp_not_queued", {29'd0, o_valid, o_ready, o_busy}, 32'd2);

      // Reset during CALC iteration 10
      issue(OP_DIVU, 32'h1234_5678, 32'd3);
      repeat (10) begin @(posedge i_clk); #1; end
      check("mid_busy", {31'd0, o_busy}, 32'd1);
      i_rst_n = 1'b0;
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      check("mid_reset_flags", {29'd0, o_valid, o_ready, o_busy}, 32'd2);
      check("mid_reset_result", o_result, 32'd0);
      run_op("after_reset", OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 0);

      // Randomized requests against the reference model
      for (int t = 0; t < 40; t++) begin
         logic [1:0] op = 2'($urandom);
         logic [31:0] a = $urandom;
         logic [31:0] b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15)) ^ (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd0);
            3: begin a = 32'($urandom_range(0, 255)); b = $urandom | 32'h0000_1000; end
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         run_op("random", op, a, b, $urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
